exu_issue_ctrl: RTL and testbench

//  Single-entry issue/sequencing controller in front of the EXU datapath.

---
 rtl/exu_issue_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_exu_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_issue_ctrl.sv
// Single-entry issue/sequencing controller between IDU and the EXU datapath.
// Optional performance counters are enabled by defining EXU_ISSUE_PERF_EN.
module exu_issue_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned OPW     = 4,
  parameter int unsigned MUL_TMO = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OPW-1:0]  id_op,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rd,
  input  logic            id_long,
  output logic [OPW-1:0]  exu_op,
  output logic [XLEN-1:0] exu_pc,
  input  logic            exu_rdy,
  input  logic            exu_pcchg,
  input  logic [XLEN-1:0] exu_pc_op,
  output logic            mul_start,
  input  logic            mul_done,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_err,
  input  logic            wb_ready,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            busy
`ifdef EXU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned   CntW    = $clog2(MUL_TMO) + 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(MUL_TMO - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StExec, StMwait, StWb} state_e;

  state_e            state_q, state_d;
  logic              live_q;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [4:0]        rd_q, rd_d;
  logic              long_q, long_d;
  logic              rdy_q, rdy_d;
  logic              pcchg_q, pcchg_d;
  logic [XLEN-1:0]   pc_op_q, pc_op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              accept;
  logic              wb_done;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    long_d      = long_q;
    rdy_d       = rdy_q;
    pcchg_d     = pcchg_q;
    pc_op_d     = pc_op_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    first_d     = first_q;
    id_ready    = 1'b0;
    exu_op      = '0;
    exu_pc      = '0;
    mul_start   = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_err      = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    wb_done     = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // live_q keeps id_ready low during reset and the cycle it is released
        id_ready = live_q;
      end
      StExec: begin
        exu_op  = op_q;
        exu_pc  = pc_q;
        rdy_d   = exu_rdy;
        pcchg_d = exu_pcchg;
        pc_op_d = exu_pc_op;
        err_d   = 1'b0;
        first_d = 1'b1;
        if (long_q) begin
          mul_start = 1'b1;
          cnt_d     = '0;
          state_d   = StMwait;
        end else begin
          state_d = StWb;
        end
      end
      StMwait: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        if (mul_done) begin
          err_d   = 1'b0;
          first_d = 1'b1;
          state_d = StWb;
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          first_d = 1'b1;
          state_d = StWb;
        end
      end
      StWb: begin
        wb_valid    = rdy_q | err_q;
        wb_rd       = rd_q;
        wb_err      = err_q;
        redir_valid = first_q & pcchg_q;
        redir_pc    = redir_valid ? pc_op_q : '0;
        wb_done     = (wb_valid & wb_ready) | ~wb_valid;
        // IDU is flushing during the redirect cycle, so no accept then
        id_ready    = wb_done & ~redir_valid;
        first_d     = 1'b0;
        if (wb_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    accept = id_valid & id_ready;
    if (accept) begin
      op_d    = id_op;
      pc_d    = id_pc;
      rd_d    = id_rd;
      long_d  = id_long;
      state_d = StExec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      op_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      long_q  <= 1'b0;
      rdy_q   <= 1'b0;
      pcchg_q <= 1'b0;
      pc_op_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      op_q    <= op_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      long_q  <= long_d;
      rdy_q   <= rdy_d;
      pcchg_q <= pcchg_d;
      pc_op_q <= pc_op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

`ifdef EXU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;
  logic        stall_cycle;

  assign stall_cycle = (state_q == StMwait) | ((state_q == StWb) & wb_valid & ~wb_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (stall_cycle) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: directed scenarios plus randomized ops
// compared against a per-transaction timing model.
module tb_exu_issue_ctrl;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned OPW     = 4;
  localparam int unsigned MUL_TMO = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic            id_ready;
  logic [OPW-1:0]  id_op;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rd;
  logic            id_long;
  logic [OPW-1:0]  exu_op;
  logic [XLEN-1:0] exu_pc;
  logic            exu_rdy;
  logic            exu_pcchg;
  logic [XLEN-1:0] exu_pc_op;
  logic            mul_start;
  logic            mul_done;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_err;
  logic            wb_ready;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            busy;
`ifdef EXU_ISSUE_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_stall;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_issued = 0;
  int unsigned exp_stall = 0;

  always #5 clk = ~clk;

  exu_issue_ctrl #(
    .XLEN    (XLEN),
    .OPW     (OPW),
    .MUL_TMO (MUL_TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_op       (id_op),
    .id_pc       (id_pc),
    .id_rd       (id_rd),
    .id_long     (id_long),
    .exu_op      (exu_op),
    .exu_pc      (exu_pc),
    .exu_rdy     (exu_rdy),
    .exu_pcchg   (exu_pcchg),
    .exu_pc_op   (exu_pc_op),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_err      (wb_err),
    .wb_ready    (wb_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .busy        (busy)
`ifdef EXU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_perf();
`ifdef EXU_ISSUE_PERF_EN
    chk("perf_issued", 64'(perf_issued), 64'(exp_issued));
    chk("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_id_ready"}, 64'(id_ready), 64'd0);
    chk({tag, "_exu_op"}, 64'(exu_op), 64'd0);
    chk({tag, "_exu_pc"}, exu_pc, 64'd0);
    chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    chk({tag, "_wb_err"}, 64'(wb_err), 64'd0);
    chk({tag, "_redir_valid"}, 64'(redir_valid), 64'd0);
    chk({tag, "_redir_pc"}, redir_pc, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk_perf();
  endtask

  // One op from IDLE back to IDLE. dly: MWAIT cycle index at which mul_done
  // rises (-1 or >= MUL_TMO means never); stall: cycles of wb_ready=0 in WB.
  task automatic run_op(input logic [OPW-1:0] op, input logic [63:0] pc, input logic [4:0] rd,
                        input bit lng, input bit rdy, input bit pcchg, input logic [63:0] pcop,
                        input int dly, input int stall);
    bit err;
    bit vld;
    bit redir;
    bit done;
    int mw_cycles;
    id_valid = 1'b1;
    id_op    = op;
    id_pc    = pc;
    id_rd    = rd;
    id_long  = lng;
    wb_ready = 1'b0;
    mul_done = 1'b0;
    #1;
    chk("idle_ready", 64'(id_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    exp_issued++;

    id_valid  = 1'b0;
    id_op     = OPW'($urandom);
    id_pc     = {$urandom, $urandom};
    id_rd     = 5'($urandom);
    id_long   = 1'($urandom);
    exu_rdy   = rdy;
    exu_pcchg = pcchg;
    exu_pc_op = pcop;
    mul_done  = 1'($urandom);
    #1;
    chk("exec_op", 64'(exu_op), 64'(op));
    chk("exec_pc", exu_pc, pc);
    chk("exec_mul_start", 64'(mul_start), 64'(lng));
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_wb_valid", 64'(wb_valid), 64'd0);
    chk("exec_id_ready", 64'(id_ready), 64'd0);
    tick();

    exu_rdy   = 1'($urandom);
    exu_pcchg = 1'($urandom);
    exu_pc_op = {$urandom, $urandom};
    err       = 1'b0;
    mw_cycles = 0;
    if (lng) begin
      err = !(dly >= 0 && dly < int'(MUL_TMO));
      for (int k = 0; k < int'(MUL_TMO); k++) begin
        mul_done = (k == dly);
        #1;
        chk("mw_mul_start", 64'(mul_start), 64'd0);
        chk("mw_wb_valid", 64'(wb_valid), 64'd0);
        chk("mw_exu_op", 64'(exu_op), 64'd0);
        chk("mw_busy", 64'(busy), 64'd1);
        exp_stall++;
        mw_cycles++;
        tick();
        if (k == dly) break;
      end
      mul_done = 1'b0;
      chk("mw_cycles", 64'(mw_cycles), err ? 64'(MUL_TMO) : 64'(dly + 1));
    end

    vld = rdy | err;
    for (int s = 0; s <= stall; s++) begin
      wb_ready = (s >= stall);
      #1;
      redir = (s == 0) && pcchg;
      done  = !vld || wb_ready;
      chk("wb_valid", 64'(wb_valid), 64'(vld));
      chk("wb_err", 64'(wb_err), 64'(err));
      if (vld) chk("wb_rd", 64'(wb_rd), 64'(rd));
      chk("redir_valid", 64'(redir_valid), 64'(redir));
      if (redir) chk("redir_pc", redir_pc, pcop);
      chk("wb_id_ready", 64'(id_ready), 64'(done && !redir));
      chk("wb_busy", 64'(busy), 64'd1);
      if (vld && !wb_ready) exp_stall++;
      tick();
      if (done) break;
    end
    wb_ready = 1'b0;
    #1;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_ready", 64'(id_ready), 64'd1);
    chk_perf();
  endtask

  initial begin
    bit lng;
    int dly;
    rst_n     = 1'b0;
    id_valid  = 1'b1;
    id_op     = '0;
    id_pc     = '0;
    id_rd     = '0;
    id_long   = 1'b0;
    exu_rdy   = 1'b0;
    exu_pcchg = 1'b0;
    exu_pc_op = '0;
    mul_done  = 1'b0;
    wb_ready  = 1'b0;

    // T1: reset held 2 cycles with id_valid high
    tick();
    chk_zero("rst1");
    tick();
    chk_zero("rst2");
    rst_n    = 1'b1;
    id_valid = 1'b0;
    #1;
    chk("rel_id_ready_same", 64'(id_ready), 64'd0);
    tick();
    chk("rel_id_ready_next", 64'(id_ready), 64'd1);

    // T2 short op, T3 jal redirect, T4 long op, T5 timeout
    run_op(4'h1, 64'h8000_0000, 5'd5, 1'b0, 1'b1, 1'b0, 64'h0, -1, 0);
    run_op(4'h6, 64'h8000_0004, 5'd1, 1'b0, 1'b1, 1'b1, 64'h8000_0010, -1, 0);
    run_op(4'h9, 64'h8000_0008, 5'd12, 1'b1, 1'b1, 1'b0, 64'h0, 4, 0);
    run_op(4'ha, 64'h8000_000c, 5'd13, 1'b1, 1'b0, 1'b0, 64'h0, -1, 1);

    // Reset in the middle of a long op: nothing may come out of it
    id_valid = 1'b1;
    id_op    = 4'hb;
    id_rd    = 5'd20;
    id_long  = 1'b1;
    tick();
    id_valid  = 1'b0;
    exu_rdy   = 1'b1;
    exu_pcchg = 1'b1;
    exu_pc_op = 64'h1234;
    tick();
    tick();
    rst_n    = 1'b0;
    mul_done = 1'b1;
    tick();
    exp_issued = 0;
    exp_stall  = 0;
    chk_zero("midrst");
    rst_n    = 1'b1;
    mul_done = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
      chk("midrst_redir", 64'(redir_valid), 64'd0);
      chk("midrst_id_ready", 64'(id_ready), 64'd1);
      tick();
    end

    // T6: backpressure for 4 cycles, then back-to-back accept
    id_valid = 1'b1;
    id_op    = 4'h2;
    id_pc    = 64'h8000_0100;
    id_rd    = 5'd7;
    id_long  = 1'b0;
    tick();
    exp_issued++;
    id_valid  = 1'b0;
    exu_rdy   = 1'b1;
    exu_pcchg = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      wb_ready = 1'b0;
      #1;
      chk("bp_wb_valid", 64'(wb_valid), 64'd1);
      chk("bp_wb_rd", 64'(wb_rd), 64'd7);
      chk("bp_id_ready", 64'(id_ready), 64'd0);
      exp_stall++;
      tick();
    end
    wb_ready = 1'b1;
    id_valid = 1'b1;
    id_op    = 4'h3;
    id_pc    = 64'h8000_0104;
    id_rd    = 5'd9;
    #1;
    chk("b2b_wb_valid", 64'(wb_valid), 64'd1);
    chk("b2b_id_ready", 64'(id_ready), 64'd1);
    tick();
    exp_issued++;
    id_valid = 1'b0;
    wb_ready = 1'b0;
    exu_rdy  = 1'b0;
    #1;
    chk("b2b_exec_op", 64'(exu_op), 64'h3);
    chk("b2b_exec_pc", exu_pc, 64'h8000_0104);
    tick();
    #1;
    chk("b2b_wb_valid2", 64'(wb_valid), 64'd0);
    chk("b2b_id_ready2", 64'(id_ready), 64'd1);
    chk_perf();
    tick();

    // Randomized ops
    for (int n = 0; n < 24; n++) begin
      lng = 1'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
      run_op(OPW'($urandom), {$urandom, $urandom}, 5'($urandom), lng, 1'($urandom),
             1'($urandom), {$urandom, $urandom}, dly, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
